// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// UART_TX_PARITY_EN adds an even-parity bit (8E1 frame) when defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int FRAME_BITS = 10;
`endif

    // Divisor rounded to nearest integer, so the bit period error stays below half a clock.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible on rdata while not empty.
// Full/empty come from an extra wrap bit on each pointer.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage is not reset; flushing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered 8N1 UART transmitter: FIFO, baud counter and frame FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    ascii_in,
    input  logic          ascii_valid,
    output logic          ascii_ready,
    output logic          tx,
    output logic          busy,
    output logic [LW-1:0] fifo_level
);

    localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW       = $clog2(BAUD_DIV);

    tx_state_t   state_reg;
    logic [CW-1:0] cnt_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx_reg;
    logic        tx_reg;
`ifdef UART_TX_PARITY_EN
    logic        parity_reg;
`endif

    logic [7:0]  head;
    logic        full;
    logic        empty;
    logic        bit_tick;
    logic        pop;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (ascii_valid),
        .wdata   (ascii_in),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign bit_tick    = (state_reg != IDLE) && (cnt_reg == CW'(BAUD_DIV - 1));
    // Pop from IDLE immediately, or at the end of a stop bit to chain frames back-to-back.
    assign pop         = !empty && ((state_reg == IDLE) || (state_reg == STOP && bit_tick));
    assign ascii_ready = !full;
    assign busy        = (state_reg != IDLE) || !empty;
    assign tx          = tx_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            // The line level follows the state one cycle later, so every bit lasts BAUD_DIV cycles.
            case (state_reg)
                START:   tx_reg <= 1'b0;
                DATA:    tx_reg <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  tx_reg <= parity_reg;
`endif
                default: tx_reg <= 1'b1;
            endcase

            if (state_reg == IDLE || bit_tick) cnt_reg <= '0;
            else                               cnt_reg <= cnt_reg + CW'(1);

            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        shift_reg   <= head;
                        bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_reg  <= ^head;
`endif
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (bit_tick) state_reg <= DATA;
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_reg   <= shift_reg >> 1;
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) state_reg <= STOP;
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        if (!empty) begin
                            shift_reg   <= head;
                            bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
                            parity_reg  <= ^head;
`endif
                            state_reg   <= START;
                        end else begin
                            state_reg   <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at 1600 Hz / 100 baud, giving a 16-cycle bit period.
// A line monitor decodes tx independently; define UART_TX_PARITY_EN to cover the parity build.
module tb_uart_tx_stream;
    import uart_pkg::*;

    localparam int D = 16;  // round(1600 / 100)

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] ascii_in = 8'h00;
    logic       ascii_valid = 1'b0;
    logic       ascii_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_level;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int mon_err = 0;

    logic [7:0] rx_q[$];
    logic       par_q[$];
    int         start_q[$];

    uart_tx_stream #(
        .CLK_HZ     (1600),
        .BAUD       (100),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ascii_in    (ascii_in),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .tx          (tx),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int bound);
        int w = 0;
        while (rx_q.size() < n && w < bound) begin
            tick();
            w++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    task automatic wait_idle(input int bound);
        int w = 0;
        while (busy && w < bound) begin
            tick();
            w++;
        end
        check("idle_busy", busy, 0);
        check("idle_level", fifo_level, 0);
    endtask

    // Line monitor: finds a start edge, samples each bit at mid-period.
    initial begin : monitor
        logic [7:0] b;
        logic       p;
        forever begin
            tick();
            if (reset_n && tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (D / 2) tick();
                if (tx !== 1'b0) mon_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (D) tick();
                    b[i] = tx;
                end
                p = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (D) tick();
                p = tx;
`endif
                repeat (D) tick();
                if (tx !== 1'b1) mon_err++;
                rx_q.push_back(b);
                par_q.push_back(p);
                repeat (D - D / 2 - 1) tick();
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int k;
        int k0;
        int sent;
        int w;
        int drop_seen;
        int acc_at_drop;
        int lvl_at_drop;
        int re_cyc;
        logic [9:0] frame;
        logic [7:0] t2_data [3];
        logic [4:0] t2_lvl [3];

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", ascii_ready, 1);
        reset_n = 1'b1;
        tick();

        // Single byte 0x41: tx low two edges after acceptance, then 10 exact bit slots
        rx_q.delete(); par_q.delete(); start_q.delete();
        ascii_in = 8'h41; ascii_valid = 1'b1;
        tick();
        ascii_valid = 1'b0;
        k = cyc;
        check("t1_level", fifo_level, 1);
        check("t1_busy", busy, 1);
        check("t1_tx_k", tx, 1);
        tick();
        check("t1_tx_k1", tx, 1);
        tick();
        frame = 10'b1_0100_0001_0;
        for (int j = 0; j < 10; j++) begin
            check("t1_slot_first", tx, frame[j]);
            if (j == 9) check("t1_busy_stop", busy, 1);
            repeat (D - 1) tick();
            check("t1_slot_last", tx, frame[j]);
            tick();
        end
        check("t1_end_cycle", cyc, k + 2 + 10 * D);
        check("t1_end_tx", tx, 1);
        check("t1_end_busy", busy, 0);
        wait_rx(1, 2 * D);
        check("t1_byte", rx_q[0], 8'h41);

        // Three back-to-back bytes, contiguous frames
        rx_q.delete(); par_q.delete(); start_q.delete();
        t2_data[0] = 8'h46; t2_data[1] = 8'h42; t2_data[2] = 8'h53;
        t2_lvl[0] = 5'd1;   t2_lvl[1] = 5'd1;   t2_lvl[2] = 5'd2;
        for (int i = 0; i < 3; i++) begin
            ascii_in = t2_data[i]; ascii_valid = 1'b1;
            check("t2_ready", ascii_ready, 1);
            tick();
            check("t2_level", fifo_level, t2_lvl[i]);
        end
        ascii_valid = 1'b0;
        wait_rx(3, 40 * D);
        for (int i = 0; i < 3; i++) check("t2_byte", rx_q[i], t2_data[i]);
        check("t2_gap01", start_q[1] - start_q[0], 10 * D);
        check("t2_gap12", start_q[2] - start_q[1], 10 * D);
        wait_idle(12 * D);

        // Valid held for 20 bytes: backpressure and no loss
        rx_q.delete(); par_q.delete(); start_q.delete();
        sent = 0; k0 = -1; w = 0; drop_seen = 0;
        acc_at_drop = -1; lvl_at_drop = -1; re_cyc = -1;
        while (sent < 20 && w < 100 * D) begin
            ascii_in = 8'(8'hA0 + sent); ascii_valid = 1'b1;
            if (ascii_ready) begin
                if (sent == 0) k0 = cyc + 1;
                if (drop_seen != 0 && re_cyc < 0) re_cyc = cyc;
                sent++;
            end else if (drop_seen == 0) begin
                drop_seen = 1;
                acc_at_drop = sent;
                lvl_at_drop = int'(fifo_level);
            end
            tick();
            w++;
        end
        ascii_valid = 1'b0;
        check("t3_sent", sent, 20);
        check("t3_accepts_at_drop", acc_at_drop, 17);
        check("t3_level_at_drop", lvl_at_drop, 16);
        check("t3_ready_back", re_cyc, k0 + 1 + 10 * D);
        wait_rx(20, 250 * D);
        for (int i = 0; i < 20; i++) check("t3_byte", rx_q[i], 8'(8'hA0 + i));
        wait_idle(12 * D);

        // Reset during data bit 3 flushes FIFO and abandons the frame
        rx_q.delete(); par_q.delete(); start_q.delete();
        ascii_in = 8'hA5; ascii_valid = 1'b1;
        tick();
        k = cyc;
        ascii_in = 8'h3C;
        tick();
        ascii_valid = 1'b0;
        repeat ((k + 2 + 4 * D + D / 2) - cyc) tick();
        check("t4_tx_bit3", tx, 0);
        check("t4_level_pre", fifo_level, 1);
        check("t4_busy_pre", busy, 1);
        reset_n = 1'b0;
        tick();
        check("t4_tx", tx, 1);
        check("t4_level", fifo_level, 0);
        check("t4_busy", busy, 0);
        check("t4_ready", ascii_ready, 1);
        reset_n = 1'b1;
        repeat (12 * D) tick();
        check("t4_busy_after", busy, 0);
        rx_q.delete(); par_q.delete(); start_q.delete();
        ascii_in = 8'h55; ascii_valid = 1'b1;
        tick();
        ascii_valid = 1'b0;
        wait_rx(1, 12 * D);
        check("t4_byte", rx_q[0], 8'h55);
        repeat (12 * D) tick();
        check("t4_no_extra", rx_q.size(), 1);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; frames 11 bit periods apart
        rx_q.delete(); par_q.delete(); start_q.delete();
        ascii_in = 8'h07; ascii_valid = 1'b1;
        tick();
        ascii_in = 8'h03;
        tick();
        ascii_valid = 1'b0;
        wait_rx(2, 30 * D);
        check("t5_byte0", rx_q[0], 8'h07);
        check("t5_par0", par_q[0], 1);
        check("t5_byte1", rx_q[1], 8'h03);
        check("t5_par1", par_q[1], 0);
        check("t5_frame_len", start_q[1] - start_q[0], FRAME_BITS * D);
        wait_idle(14 * D);
`endif

        check("monitor_framing", mon_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
